// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: clock inhibit, request-to-send, 8 data bits
// LSB first with odd parity, stop bit release, device ACK sampling and timeout.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SEND, S_WAIT_ACK, S_WAIT_IDLE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    n_q, n_d;
  logic [8:0]    shift_q, shift_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [2:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          clk_s, data_s, fall, timeout;

  // Stage 2 is the synchronized level; stage 3 only exists for edge detection.
  assign clk_s   = clk_sync_q[1];
  assign data_s  = data_sync_q[1];
  assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
    end else begin
      clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      n_q       <= '0;
      shift_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      shift_q   <= shift_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    shift_d   = shift_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ack_d     = ack_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_start) begin
          shift_d  = {~^tx_data, tx_data};
          ack_d    = 1'b0;
          err_d    = 1'b0;
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          cnt_d     = '0;
          n_d       = '0;
          state_d   = S_RTS;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RTS, S_SEND, S_WAIT_ACK, S_WAIT_IDLE: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          err_d     = 1'b1;
          ack_d     = 1'b0;
          state_d   = S_DONE;
        end else begin
          // shift_q[0] always holds the next bit to present: data LSB first, then parity.
          case (state_q)
            S_RTS: begin
              if (fall) begin
                n_d       = 4'd1;
                data_oe_d = ~shift_q[0];
                shift_d   = shift_q >> 1;
                state_d   = S_SEND;
              end
            end
            S_SEND: begin
              if (fall) begin
                n_d = n_q + 4'd1;
                if (n_q == 4'd9) begin
                  data_oe_d = 1'b0;
                  state_d   = S_WAIT_ACK;
                end else begin
                  data_oe_d = ~shift_q[0];
                  shift_d   = shift_q >> 1;
                end
              end
            end
            S_WAIT_ACK: begin
              if (fall) begin
                ack_d   = ~data_s;
                err_d   = data_s;
                state_d = S_WAIT_IDLE;
              end
            end
            default: begin
              if (clk_s && data_s) state_d = S_DONE;
            end
          endcase
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign ack_ok      = ack_q;
  assign error       = err_q;

endmodule
